// File: rtl/btb_predictor_pkg.sv
// Shared constants and types for the fetch-stage branch target buffer.
// Holds the table geometry, counter reset/allocate values and the update action encoding.
package btb_predictor_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_W   = 4;
  localparam int BTB_TAG_W   = 32 - BTB_IDX_W - 2;

  localparam logic [1:0] CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  // What an execute-stage resolution does to the addressed slot.
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_action_e;

endpackage

// File: rtl/btb_predictor_sat_cnt2.sv
// Two-bit saturating counter next-state logic for the bimodal direction predictor.
// Purely combinational; the caller owns the counter storage.
module sat_cnt2 (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry 2-bit bimodal counters, looked up combinationally on the fetch PC.
// Trained by execute-stage resolutions; only taken branches allocate entries.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = BTB_IDX_W,
  parameter int TAG_W   = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic [31:0] pre_pc_o,
  output logic        hit_o,
  output logic        predict_taken_o,
  output logic [31:0] btb_addr_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         cnt_mem    [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_nxt;
  upd_action_e      action;
  logic [1:0]       upd_pc_unused;

  assign upd_pc_unused = upd_pc_i[1:0];

  // Lookup; hit is also gated by rst so the miss values appear the instant reset asserts.
  always_comb begin
    look_idx        = pc_i[IDX_W+1:2];
    look_tag        = pc_i[31:IDX_W+2];
    look_hit        = rst & valid[look_idx] & (tag_mem[look_idx] == look_tag);
    hit_o           = look_hit;
    predict_taken_o = look_hit & cnt_mem[look_idx][1];
    btb_addr_o      = look_hit ? target_mem[look_idx] : 32'd0;
    pre_pc_o        = predict_taken_o ? target_mem[look_idx] : pc_i + 32'd4;
  end

  always_comb begin
    uidx    = upd_pc_i[IDX_W+1:2];
    utag    = upd_pc_i[31:IDX_W+2];
    uhit    = valid[uidx] & (tag_mem[uidx] == utag);
    cnt_cur = cnt_mem[uidx];
    action  = UPD_NONE;
    if (upd_valid_i) begin
      if (uhit)             action = UPD_TRAIN;
      else if (upd_taken_i) action = UPD_ALLOC;
    end
  end

  sat_cnt2 u_sat_cnt2 (
    .cnt     (cnt_cur),
    .taken   (upd_taken_i),
    .cnt_nxt (cnt_nxt)
  );

  // Valid bits and counters need the asynchronous clear, so they live apart from tag/target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_mem[i] <= CNT_WEAK_NT;
    end else begin
      case (action)
        UPD_TRAIN: cnt_mem[uidx] <= cnt_nxt;
        UPD_ALLOC: begin
          valid[uidx]   <= 1'b1;
          cnt_mem[uidx] <= CNT_WEAK_T;
        end
        default: ;
      endcase
    end
  end

  // Tag and target are meaningless while invalid, so they skip the reset network.
  always_ff @(posedge clk) begin
    if (rst) begin
      case (action)
        UPD_TRAIN: begin
          if (upd_taken_i) target_mem[uidx] <= upd_target_i;
        end
        UPD_ALLOC: begin
          tag_mem[uidx]    <= utag;
          target_mem[uidx] <= upd_target_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed literal checks plus randomized traffic
// compared every cycle against an index-keyed model of owner PCs, targets and counters.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] pre_pc_o;
  logic        hit_o;
  logic        predict_taken_o;
  logic [31:0] btb_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  int checks = 0;
  int fails  = 0;

  btb_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .pre_pc_o        (pre_pc_o),
    .hit_o           (hit_o),
    .predict_taken_o (predict_taken_o),
    .btb_addr_o      (btb_addr_o),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i)
  );

  always #5 clk = ~clk;

  // Model: each slot remembers the full PC of the branch that owns it.
  bit          m_valid  [16];
  logic [31:0] m_owner  [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit same_branch(input logic [31:0] a, input logic [31:0] b);
    return (a >> 6) == (b >> 6);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
    end else if (upd_valid_i) begin
      int s;
      s = slot_of(upd_pc_i);
      if (m_valid[s] && same_branch(m_owner[s], upd_pc_i)) begin
        if (upd_taken_i) begin
          m_cnt[s]    = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_target[s] = upd_target_i;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (upd_taken_i) begin
        m_valid[s]  = 1'b1;
        m_owner[s]  = upd_pc_i;
        m_target[s] = upd_target_i;
        m_cnt[s]    = 2;
      end
    end
  end

  always @(negedge clk) begin
    int s;
    bit e_hit, e_tk;
    logic [31:0] e_addr, e_pre;
    s      = slot_of(pc_i);
    e_hit  = rst && m_valid[s] && same_branch(m_owner[s], pc_i);
    e_tk   = e_hit && (m_cnt[s] >= 2);
    e_addr = e_hit ? m_target[s] : 32'd0;
    e_pre  = e_tk ? m_target[s] : pc_i + 32'd4;
    checks++;
    if (hit_o !== e_hit || predict_taken_o !== e_tk || btb_addr_o !== e_addr || pre_pc_o !== e_pre) begin
      fails++;
      $display("[TB] FAIL model pc=%h: got hit=%b tk=%b addr=%h pre=%h, expected hit=%b tk=%b addr=%h pre=%h",
               pc_i, hit_o, predict_taken_o, btb_addr_o, pre_pc_o, e_hit, e_tk, e_addr, e_pre);
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt);
    @(posedge clk);
    #1;
    pc_i         = pc;
    upd_valid_i  = uv;
    upd_pc_i     = upc;
    upd_taken_i  = ut;
    upd_target_i = utgt;
  endtask

  task automatic checkOutput(input string name, input logic e_hit, input logic e_tk,
                             input logic [31:0] e_addr, input logic [31:0] e_pre);
    #2;
    checks++;
    if (hit_o !== e_hit || predict_taken_o !== e_tk || btb_addr_o !== e_addr || pre_pc_o !== e_pre) begin
      fails++;
      $display("[TB] FAIL %s: got hit=%b tk=%b addr=%h pre=%h, expected hit=%b tk=%b addr=%h pre=%h",
               name, hit_o, predict_taken_o, btb_addr_o, pre_pc_o, e_hit, e_tk, e_addr, e_pre);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
    return 32'h8000_0000 | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    rst = 1'b0;
    pc_i = 32'h8000_0000;
    upd_valid_i = 1'b0;
    upd_pc_i = 32'd0;
    upd_taken_i = 1'b0;
    upd_target_i = 32'd0;

    applyStimulus(32'h8000_0000, 0, 0, 0, 0);
    checkOutput("in_reset", 0, 0, 32'd0, 32'h8000_0004);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(32'h8000_0000, 0, 0, 0, 0);
    checkOutput("after_reset", 0, 0, 32'd0, 32'h8000_0004);

    applyStimulus(32'h8000_0000, 1, 32'h8000_0010, 1, 32'h8000_0100);
    applyStimulus(32'h8000_0010, 0, 0, 0, 0);
    checkOutput("alloc_hit", 1, 1, 32'h8000_0100, 32'h8000_0100);

    applyStimulus(32'h8000_0010, 1, 32'h8000_0010, 0, 0);
    applyStimulus(32'h8000_0010, 1, 32'h8000_0010, 0, 0);
    checkOutput("cnt_weak_nt", 1, 0, 32'h8000_0100, 32'h8000_0014);
    applyStimulus(32'h8000_0010, 0, 0, 0, 0);
    checkOutput("cnt_strong_nt", 1, 0, 32'h8000_0100, 32'h8000_0014);
    repeat (4) applyStimulus(32'h8000_0010, 1, 32'h8000_0010, 1, 32'h8000_0100);
    applyStimulus(32'h8000_0010, 1, 32'h8000_0010, 0, 0);
    checkOutput("cnt_saturated", 1, 1, 32'h8000_0100, 32'h8000_0100);
    applyStimulus(32'h8000_0010, 1, 32'h8000_0010, 0, 0);
    checkOutput("cnt_after_one_nt", 1, 1, 32'h8000_0100, 32'h8000_0100);
    applyStimulus(32'h8000_0010, 0, 0, 0, 0);
    checkOutput("cnt_after_two_nt", 1, 0, 32'h8000_0100, 32'h8000_0014);

    applyStimulus(32'h8000_0000, 1, 32'h8000_0050, 1, 32'h8000_0200);
    applyStimulus(32'h8000_0010, 0, 0, 0, 0);
    checkOutput("alias_evicted", 0, 0, 32'd0, 32'h8000_0014);
    applyStimulus(32'h8000_0050, 0, 0, 0, 0);
    checkOutput("alias_new_owner", 1, 1, 32'h8000_0200, 32'h8000_0200);

    applyStimulus(32'h8000_0020, 1, 32'h8000_0020, 1, 32'h8000_0300);
    checkOutput("same_cycle_no_bypass", 0, 0, 32'd0, 32'h8000_0024);
    applyStimulus(32'h8000_0020, 0, 0, 0, 0);
    checkOutput("same_cycle_next", 1, 1, 32'h8000_0300, 32'h8000_0300);
    applyStimulus(32'hFFFF_FFFC, 0, 0, 0, 0);
    checkOutput("pc_wrap", 0, 0, 32'd0, 32'h0000_0000);

    applyStimulus(32'h8000_0020, 1, 32'h8000_0060, 1, 32'h8000_0400);
    #1 rst = 1'b0;
    checkOutput("reset_mid_run", 0, 0, 32'd0, 32'h8000_0024);
    @(posedge clk);
    #1;
    rst = 1'b1;
    upd_valid_i = 1'b0;
    pc_i = 32'h8000_0060;
    checkOutput("pending_discarded", 0, 0, 32'd0, 32'h8000_0064);
    applyStimulus(32'h8000_0020, 0, 0, 0, 0);
    checkOutput("prior_entry_cleared", 0, 0, 32'd0, 32'h8000_0024);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
